// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions.
// Widths, PC step and the buffer entry layout.
package instruction_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  localparam int DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO with flush.
// Power-of-two depth so pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic doPush;
  logic doPop;

  assign full = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr <= wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      if (doPush && !doPop) begin
        count <= count + CW'(1);
      end else if (doPop && !doPush) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues in-order memory reads and buffers
// returned words for decode, dropping responses killed by redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pcAdvance,
  input  logic              redirect,
  output logic              memReqValid,
  output logic [ADDR_W-1:0] memReqAddr,
  input  logic              memReqReady,
  input  logic              memRespValid,
  input  logic [INSTR_W-1:0] memRespData,
  output logic              instrValid,
  output logic [INSTR_W-1:0] instrData,
  output logic [ADDR_W-1:0] instrPc,
  input  logic              instrReady
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] outCnt;
  logic [CW-1:0] bufCnt;
  logic [CW-1:0] dropCnt;
  logic [CW:0] inUse;
  logic aqFull;
  logic aqEmpty;
  logic bufFull;
  logic bufEmpty;
  logic [ADDR_W-1:0] headAddr;
  fetch_entry_t bufIn;
  fetch_entry_t bufOut;
  logic misaligned;
  logic misSticky;
  logic accept;
  logic respPop;
  logic respKeep;
  logic xfer;

  assign inUse = {1'b0, outCnt} + {1'b0, bufCnt};
  assign misaligned = (pc[1:0] != 2'b00) || misSticky;

  assign memReqValid = !rst && !redirect && !misaligned
                    && !aqFull && !bufFull
                    && (inUse < (CW+1)'(DEPTH));
  assign memReqAddr = pc;
  assign accept = memReqValid && memReqReady;
  assign pcAdvance = accept;

  // Every response retires one queued address, kept or not.
  assign respPop = memRespValid && !aqEmpty;
  assign respKeep = respPop && (dropCnt == '0) && !redirect;

  assign instrValid = !rst && !redirect && !bufEmpty;
  assign xfer = instrValid && instrReady;

  assign bufIn = '{pc: headAddr, instr: memRespData};
  assign instrPc = bufOut.pc;
  assign instrData = bufOut.instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropCnt <= '0;
      misSticky <= 1'b0;
    end else begin
      if (redirect) begin
        dropCnt <= outCnt - CW'(respPop);
      end else if (respPop && dropCnt != '0) begin
        dropCnt <= dropCnt - CW'(1);
      end
      misSticky <= redirect ? 1'b0 : misaligned;
    end
  end

  fetch_fifo #(
    .WIDTH(ADDR_W),
    .DEPTH(DEPTH)
  ) addrQ (
    .clk      (clk),
    .rst      (rst),
    .flush    (1'b0),
    .push     (accept),
    .pushData (pc),
    .pop      (respPop),
    .popData  (headAddr),
    .full     (aqFull),
    .empty    (aqEmpty),
    .count    (outCnt)
  );

  fetch_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) instrBuf (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (respKeep),
    .pushData (bufIn),
    .pop      (xfer),
    .popData  (bufOut),
    .full     (bufFull),
    .empty    (bufEmpty),
    .count    (bufCnt)
  );

endmodule
